mem_stage: RTL

Fourth pipeline stage of the LoongArch core, between execute and write-back. Each cycle it accepts one instruction from execute over a valid/allowin handshake, waits for the data-SRAM response when the instruction issued a memory access, and extracts and sign- or zero-extends load data. It forwards the final result to write-back and publishes a forwarding/interlock bus to decode. A one-entry response buffer holds data that arrives while write-back is stalled.

---
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage.sv | 86 ++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute, write-back, forwarding and data-SRAM response signals of mem_stage
interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 75,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int MS_FWD_BUS_WD   = 39
);
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FWD_BUS_WD-1:0]   ms_to_ds_fwd_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;

    modport master (
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_fwd_bus,
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_fwd_bus,
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: waits for the data-SRAM response, extracts load data, forwards to write-back
module mem_stage (
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave mif
);
    logic        r_ms_valid;
    logic [74:0] r_es_to_ms_bus;
    logic [31:0] r_rdata_buf;
    logic        r_buf_valid;

    logic        w_mem_req;
    logic [2:0]  w_ld_type;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;

    assign {w_mem_req, w_ld_type, w_res_from_mem, w_gr_we, w_dest, w_alu_result, w_pc} = r_es_to_ms_bus;

    logic w_ready_go;
    logic w_allowin;
    logic w_accept;
    logic w_leave;
    logic w_capture;

    assign w_ready_go = !w_mem_req || mif.data_sram_data_ok || r_buf_valid;
    assign w_allowin  = !r_ms_valid || (w_ready_go && mif.ws_allowin);
    assign w_accept   = mif.es_to_ms_valid && w_allowin;
    assign w_leave    = r_ms_valid && w_ready_go && mif.ws_allowin;
    // A response that arrives while write-back stalls must survive until the hand-off.
    assign w_capture  = mif.data_sram_data_ok && r_ms_valid && w_mem_req && !r_buf_valid && !mif.ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid     <= 1'b0;
            r_es_to_ms_bus <= '0;
            r_rdata_buf    <= '0;
            r_buf_valid    <= 1'b0;
        end else begin
            if (w_allowin) begin
                r_ms_valid <= mif.es_to_ms_valid;
            end
            if (w_accept) begin
                r_es_to_ms_bus <= mif.es_to_ms_bus;
            end
            if (w_leave) begin
                r_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_buf_valid <= 1'b1;
                r_rdata_buf <= mif.data_sram_rdata;
            end
        end
    end

    logic [31:0] w_mem_rdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_result;
    logic [31:0] w_final_result;

    assign w_mem_rdata = r_buf_valid ? r_rdata_buf : mif.data_sram_rdata;
    assign w_byte      = w_mem_rdata[{w_alu_result[1:0], 3'b000} +: 8];
    assign w_half      = w_alu_result[1] ? w_mem_rdata[31:16] : w_mem_rdata[15:0];

    always_comb begin
        w_load_result = w_mem_rdata;
        case (w_ld_type)
            3'b001:  w_load_result = {{24{w_byte[7]}}, w_byte};
            3'b011:  w_load_result = {24'h0, w_byte};
            3'b010:  w_load_result = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_result = {16'h0, w_half};
            default: w_load_result = w_mem_rdata;
        endcase
    end

    assign w_final_result = w_res_from_mem ? w_load_result : w_alu_result;

    assign mif.ms_allowin       = w_allowin;
    assign mif.ms_to_ws_valid   = r_ms_valid && w_ready_go;
    assign mif.ms_to_ws_bus     = {w_gr_we, w_dest, w_final_result, w_pc};
    assign mif.ms_to_ds_fwd_bus = {r_ms_valid && w_gr_we && (w_dest != 5'd0),
                                   r_ms_valid && w_res_from_mem && !w_ready_go,
                                   w_dest, w_final_result};
endmodule
